// File: rtl/halt_step_if.sv
// Halt/step sequencer bus: pipeline status in, freeze and debug status out.
// The master side is the core/debugger, the slave side is the sequencer.
interface halt_step_if #(
  parameter int unsigned CNT_W = 32
);
  logic [6:0]       opcode;
  logic             flush_in;
  logic             stall_in;
  logic             dbg_halt_req;
  logic             dbg_resume;
  logic             dbg_step;
  logic             halt_coman;
  logic             halted;
  logic [1:0]       state_o;
  logic [1:0]       halt_cause;
  logic             step_done;
  logic [CNT_W-1:0] run_cycles;

  modport master (
    output opcode,
    output flush_in,
    output stall_in,
    output dbg_halt_req,
    output dbg_resume,
    output dbg_step,
    input  halt_coman,
    input  halted,
    input  state_o,
    input  halt_cause,
    input  step_done,
    input  run_cycles
  );

  modport slave (
    input  opcode,
    input  flush_in,
    input  stall_in,
    input  dbg_halt_req,
    input  dbg_resume,
    input  dbg_step,
    output halt_coman,
    output halted,
    output state_o,
    output halt_cause,
    output step_done,
    output run_cycles
  );
endinterface

// File: rtl/halt_step_ctrl.sv
// Run/halt/single-step sequencer driving the core's halt_coman freeze.
// Freezes on a halt opcode in ID or a debug request, drains, then halts.
module halt_step_ctrl #(
  parameter logic [6:0]  HALT_OPCODE = 7'h7F,
  parameter int unsigned DRAIN_CYC   = 3,
  parameter int unsigned CNT_W       = 32
) (
  input  logic        clk,
  input  logic        reset,
  halt_step_if.slave  bus
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;
  localparam logic [1:0] S_STEP   = 2'd3;

  localparam logic [1:0] C_NONE = 2'd0;
  localparam logic [1:0] C_DBG  = 2'd1;
  localparam logic [1:0] C_OPC  = 2'd2;

  localparam bit NO_DRAIN = (DRAIN_CYC <= 1);
  localparam int DW =
    NO_DRAIN ? 1 : $clog2(DRAIN_CYC);

  // The freeze cycle is the first drain cycle, so
  // DRAIN lasts DRAIN_CYC-1 cycles.
  localparam logic [DW-1:0] DRAIN_LAST =
    DW'(NO_DRAIN ? 0 : DRAIN_CYC - 2);
  localparam logic [1:0] S_FRZ =
    NO_DRAIN ? S_HALTED : S_DRAIN;

  logic [1:0]       state_q, state_d;
  logic [1:0]       cause_q, cause_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] run_q, run_d;

  logic hit;
  logic go;
  logic hc;

  always_comb begin
    hit = (bus.opcode == HALT_OPCODE)
        & ~bus.flush_in;
    go  = ~bus.stall_in & ~bus.flush_in
        & ~hit;
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    done_d  = 1'b0;
    hc      = 1'b1;
    unique case (state_q)
      S_RUN: begin
        hc = hit | bus.dbg_halt_req;
        if (hit) begin
          state_d = S_FRZ;
          cause_d = C_OPC;
          cnt_d   = '0;
        end else if (bus.dbg_halt_req) begin
          state_d = S_FRZ;
          cause_d = C_DBG;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        hc    = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_HALTED;
          cnt_d   = '0;
          done_d  = step_q;
          step_d  = 1'b0;
        end
      end
      S_HALTED: begin
        hc = 1'b1;
        if (cause_q == C_DBG) begin
          if (bus.dbg_resume) begin
            state_d = S_RUN;
            cause_d = C_NONE;
          end else if (bus.dbg_step) begin
            state_d = S_STEP;
          end
        end
      end
      S_STEP: begin
        hc = ~go;
        if (hit) begin
          state_d = S_FRZ;
          cause_d = C_OPC;
          cnt_d   = '0;
          step_d  = 1'b0;
        end else if (go) begin
          state_d = S_FRZ;
          cnt_d   = '0;
          step_d  = ~NO_DRAIN;
          done_d  = NO_DRAIN;
        end
      end
      default: begin
        hc      = 1'b1;
        state_d = S_RUN;
      end
    endcase
  end

  // Wraps freely; never saturates.
  always_comb begin
    run_d = hc ? run_q : run_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RUN;
      cause_q <= C_NONE;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      done_q  <= done_d;
      run_q   <= run_d;
    end
  end

  assign bus.halt_coman = hc;
  assign bus.halted     = (state_q == S_HALTED);
  assign bus.state_o    = state_q;
  assign bus.halt_cause = cause_q;
  assign bus.step_done  = done_q;
  assign bus.run_cycles = run_q;

endmodule

// File: tb/tb_halt_step_ctrl.sv
// Directed scoreboard bench for halt_step_ctrl.
// A second 4-bit-counter instance shares the stimulus for wrap checks.
module tb_halt_step_ctrl;

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;
  localparam logic [1:0] STEP   = 2'd3;

  localparam int K_HC    = 0;
  localparam int K_HLT   = 1;
  localparam int K_ST    = 2;
  localparam int K_CAUSE = 3;
  localparam int K_DONE  = 4;
  localparam int K_RUN   = 5;
  localparam int K_RUN4  = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       flush_in;
  logic       stall_in;
  logic       dbg_halt_req;
  logic       dbg_resume;
  logic       dbg_step;

  halt_step_if #(.CNT_W(32)) ifa ();
  halt_step_if #(.CNT_W(4))  ifb ();

  assign ifa.opcode       = opcode;
  assign ifa.flush_in     = flush_in;
  assign ifa.stall_in     = stall_in;
  assign ifa.dbg_halt_req = dbg_halt_req;
  assign ifa.dbg_resume   = dbg_resume;
  assign ifa.dbg_step     = dbg_step;
  assign ifb.opcode       = opcode;
  assign ifb.flush_in     = flush_in;
  assign ifb.stall_in     = stall_in;
  assign ifb.dbg_halt_req = dbg_halt_req;
  assign ifb.dbg_resume   = dbg_resume;
  assign ifb.dbg_step     = dbg_step;

  halt_step_ctrl #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  halt_step_ctrl #(.CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          k;
    logic [31:0] v;
  } exp_t;

  exp_t        sbq[$];
  int          ncmp = 0;
  int          nfail = 0;
  logic [31:0] run_m = '0;
  bit          cyc_run = 1'b0;

  function automatic logic [31:0] obs(input int k);
    case (k)
      K_HC:    return {31'd0, ifa.halt_coman};
      K_HLT:   return {31'd0, ifa.halted};
      K_ST:    return {30'd0, ifa.state_o};
      K_CAUSE: return {30'd0, ifa.halt_cause};
      K_DONE:  return {31'd0, ifa.step_done};
      K_RUN:   return ifa.run_cycles;
      K_RUN4:  return {28'd0, ifb.run_cycles};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic ex(input string tag, input int k,
                    input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.k   = k;
    e.v   = v;
    sbq.push_back(e);
  endtask

  task automatic st(input string tag,
                    input logic [1:0] s,
                    input logic hc);
    ex({tag, "_state"}, K_ST, {30'd0, s});
    ex({tag, "_hc"}, K_HC, {31'd0, hc});
    cyc_run = ~hc;
  endtask

  task automatic tick();
    exp_t        e;
    logic [31:0] o;
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = obs(e.k);
      ncmp++;
      assert (o === e.v) else begin
        nfail++;
        $error("FAIL %s: got %0h expected %0h",
               e.tag, o, e.v);
      end
    end
    if (reset) run_m = '0;
    else if (cyc_run) run_m = run_m + 1;
    cyc_run = 1'b0;
    @(negedge clk);
    dbg_halt_req = 1'b0;
    dbg_resume   = 1'b0;
    dbg_step     = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    opcode       = 7'h33;
    flush_in     = 1'b0;
    stall_in     = 1'b0;
    dbg_halt_req = 1'b0;
    dbg_resume   = 1'b0;
    dbg_step     = 1'b0;
    @(negedge clk);
    tick();
    reset = 1'b0;

    // plain run: counter follows every unfrozen cycle
    for (int i = 0; i < 10; i++) begin
      st("run", RUN, 1'b0);
      ex("run_cnt", K_RUN, run_m);
      if (i == 0) begin
        ex("rst_halted", K_HLT, 0);
        ex("rst_cause", K_CAUSE, 0);
        ex("rst_done", K_DONE, 0);
      end
      tick();
    end
    st("run10", RUN, 1'b0);
    ex("run10_cnt", K_RUN, 32'd10);
    ex("run10_cnt4", K_RUN4, 32'd10);
    tick();

    // halt opcode in ID
    opcode = 7'h7F;
    st("op_frz", RUN, 1'b1);
    tick();
    st("op_d1", DRAIN, 1'b1);
    ex("op_cause", K_CAUSE, 2);
    ex("op_hlt1", K_HLT, 0);
    tick();
    st("op_d2", DRAIN, 1'b1);
    ex("op_hlt2", K_HLT, 0);
    tick();
    st("op_halt", HALTED, 1'b1);
    ex("op_halted", K_HLT, 1);
    ex("op_run", K_RUN, run_m);
    tick();
    dbg_resume = 1'b1;
    st("op_res", HALTED, 1'b1);
    tick();
    dbg_step = 1'b1;
    st("op_res_ign", HALTED, 1'b1);
    ex("op_cause_keep", K_CAUSE, 2);
    tick();
    st("op_step_ign", HALTED, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    opcode = 7'h33;

    // flushed halt opcode, then debug halt/resume
    opcode   = 7'h7F;
    flush_in = 1'b1;
    st("fl_nohit", RUN, 1'b0);
    tick();
    opcode   = 7'h33;
    flush_in = 1'b0;
    st("fl_run", RUN, 1'b0);
    ex("fl_cause", K_CAUSE, 0);
    tick();
    dbg_halt_req = 1'b1;
    st("dq_frz", RUN, 1'b1);
    tick();
    st("dq_d1", DRAIN, 1'b1);
    ex("dq_cause", K_CAUSE, 1);
    tick();
    dbg_step   = 1'b1;
    dbg_resume = 1'b1;
    st("dq_d2", DRAIN, 1'b1);
    tick();
    st("dq_halt", HALTED, 1'b1);
    ex("dq_halted", K_HLT, 1);
    tick();
    dbg_resume = 1'b1;
    st("dq_res", HALTED, 1'b1);
    tick();
    st("dq_run", RUN, 1'b0);
    ex("dq_cause0", K_CAUSE, 0);
    ex("dq_hlt0", K_HLT, 0);
    tick();

    // single step held off by a load-use stall
    dbg_halt_req = 1'b1;
    st("sp_frz", RUN, 1'b1);
    tick();
    st("sp_d1", DRAIN, 1'b1);
    tick();
    st("sp_d2", DRAIN, 1'b1);
    tick();
    dbg_step = 1'b1;
    stall_in = 1'b1;
    st("sp_req", HALTED, 1'b1);
    tick();
    st("sp_stall1", STEP, 1'b1);
    tick();
    st("sp_stall2", STEP, 1'b1);
    tick();
    stall_in = 1'b0;
    st("sp_go", STEP, 1'b0);
    tick();
    st("sp_d3", DRAIN, 1'b1);
    ex("sp_done0", K_DONE, 0);
    tick();
    st("sp_d4", DRAIN, 1'b1);
    ex("sp_done1", K_DONE, 0);
    tick();
    st("sp_halt", HALTED, 1'b1);
    ex("sp_done", K_DONE, 1);
    ex("sp_cause", K_CAUSE, 1);
    ex("sp_run", K_RUN, run_m);
    tick();

    // step and resume together: resume wins
    dbg_step   = 1'b1;
    dbg_resume = 1'b1;
    st("sr_req", HALTED, 1'b1);
    ex("sr_done_clr", K_DONE, 0);
    tick();
    st("sr_run", RUN, 1'b0);
    tick();

    // opcode hit beats a simultaneous debug request
    dbg_halt_req = 1'b1;
    opcode       = 7'h7F;
    st("bo_frz", RUN, 1'b1);
    tick();
    opcode = 7'h33;
    st("bo_d1", DRAIN, 1'b1);
    ex("bo_cause", K_CAUSE, 2);
    tick();
    st("bo_d2", DRAIN, 1'b1);
    tick();
    st("bo_halt", HALTED, 1'b1);
    tick();

    // debug request during reset is dropped
    reset        = 1'b1;
    dbg_halt_req = 1'b1;
    tick();
    reset = 1'b0;
    st("rq_drop", RUN, 1'b0);
    ex("rq_cause", K_CAUSE, 0);
    tick();

    // reset in the second drain cycle
    dbg_halt_req = 1'b1;
    st("rm_frz", RUN, 1'b1);
    tick();
    st("rm_d1", DRAIN, 1'b1);
    tick();
    reset = 1'b1;
    st("rm_d2", DRAIN, 1'b1);
    tick();
    reset = 1'b0;
    st("rm_run", RUN, 1'b0);
    ex("rm_hlt", K_HLT, 0);
    ex("rm_cause", K_CAUSE, 0);
    ex("rm_cnt", K_RUN, run_m);
    ex("rm_done", K_DONE, 0);
    tick();

    // halt opcode arriving while stepping
    dbg_halt_req = 1'b1;
    st("sh_frz", RUN, 1'b1);
    tick();
    st("sh_d1", DRAIN, 1'b1);
    tick();
    st("sh_d2", DRAIN, 1'b1);
    tick();
    dbg_step = 1'b1;
    st("sh_req", HALTED, 1'b1);
    tick();
    opcode = 7'h7F;
    st("sh_hit", STEP, 1'b1);
    tick();
    opcode = 7'h33;
    st("sh_d3", DRAIN, 1'b1);
    ex("sh_cause", K_CAUSE, 2);
    tick();
    st("sh_d4", DRAIN, 1'b1);
    tick();
    st("sh_halt", HALTED, 1'b1);
    ex("sh_nodone", K_DONE, 0);
    tick();

    // counter wrap on the 4-bit instance
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      st("wr", RUN, 1'b0);
      ex("wr_cnt4", K_RUN4, run_m & 32'hF);
      tick();
    end
    st("wr_end", RUN, 1'b0);
    ex("wr_cnt4_zero", K_RUN4, 32'd0);
    ex("wr_cnt32", K_RUN, 32'd16);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
